// File: rtl/axi_lite_pkg.sv
// Shared response codes, FSM state types and index-width helper for the AXI4-Lite slave memory.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_mem_array.sv
// DEPTH x DATA_W register array: one byte-strobed write port, one combinational read port,
// synchronously cleared on ARESET.
module axi_lite_mem_array
  import axi_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int NB = DATA_W / 8;

  logic [DEPTH-1:0][NB-1:0][7:0] mem;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      mem <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (wr_strb[b]) mem[wr_idx][b] <= wr_data[8*b +: 8];
    end
  end

  // Read sees the array before this edge's write, giving old-data on a same-edge collision.
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave memory with independent read/write FSMs and SLVERR on bad addresses.
// Define AXI_MEM_UNALIGNED_ERR_EN to also reject addresses with nonzero sub-word bits.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = clog2(NB);
  localparam int IDX_W = clog2(DEPTH);

  w_state_e            w_state;
  r_state_e            r_state;
  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [NB-1:0]       w_strb_q;

  logic                aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
  logic [ADDR_W-1:0]   wa;
  logic [DATA_W-1:0]   wd, rd_data;
  logic [NB-1:0]       ws;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic err;
    err = (a >> LSB) >= ADDR_W'(DEPTH);
`ifdef AXI_MEM_UNALIGNED_ERR_EN
    err = err | (a[LSB-1:0] != '0);
`endif
    return err;
  endfunction

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // Merge held captures with this cycle's handshakes so the commit lands on the last handshake edge.
  assign wa     = aw_held ? aw_addr_q : AWADDR;
  assign wd     = w_held  ? w_data_q  : WDATA;
  assign ws     = w_held  ? w_strb_q  : WSTRB;
  assign commit = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_err = addr_err(wa);
  assign rd_err = addr_err(ARADDR);

  axi_lite_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .wr_en   (commit & ~wr_err),
    .wr_idx  (wa[LSB +: IDX_W]),
    .wr_data (wd),
    .wr_strb (ws),
    .rd_idx  (ARADDR[LSB +: IDX_W]),
    .rd_data (rd_data)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      AWREADY   <= 1'b1;
      WREADY    <= 1'b1;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) aw_addr_q <= AWADDR;
          if (w_hs) begin
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
          end
          if (commit) begin
            BVALID  <= 1'b1;
            BRESP   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              AWREADY <= 1'b0;
            end
            if (w_hs) begin
              w_held <= 1'b1;
              WREADY <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RRESP   <= RESP_OKAY;
      RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            RDATA   <= rd_err ? '0 : rd_data;
            RRESP   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem: vector table plus hand sequences for ordering,
// backpressure, same-edge collision and mid-transaction reset.
module tb_axi_lite_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int vecs = 0;
  int miscompares = 0;

`ifdef AXI_MEM_UNALIGNED_ERR_EN
  localparam logic [1:0]  UA_BRESP = 2'b10;
  localparam logic [31:0] UA_WORD0 = 32'h0000_0078;
  localparam logic [31:0] UA_RDATA = 32'h0000_0000;
  localparam logic [1:0]  UA_RRESP = 2'b10;
`else
  localparam logic [1:0]  UA_BRESP = 2'b00;
  localparam logic [31:0] UA_WORD0 = 32'hFFFF_FFFF;
  localparam logic [31:0] UA_RDATA = 32'hFFFF_FFFF;
  localparam logic [1:0]  UA_RRESP = 2'b00;
`endif

  axi_lite_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // AW and W presented together; BVALID must follow one cycle after the handshake.
  task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] resp);
    @(negedge ACLK);
    AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1; BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk({nm, "_bvalid"}, 32'(BVALID), 32'd1);
    chk({nm, "_bresp"}, 32'(BRESP), 32'(resp));
    AWVALID = 1'b0; WVALID = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk({nm, "_bdone"}, 32'({BVALID, AWREADY, WREADY}), 32'b011);
  endtask

  task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] resp);
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk({nm, "_rvalid"}, 32'({RVALID, ARREADY}), 32'b10);
    chk({nm, "_rdata"}, RDATA, d);
    chk({nm, "_rresp"}, 32'(RRESP), 32'(resp));
    ARVALID = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk({nm, "_rdone"}, 32'({RVALID, ARREADY}), 32'b01);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 32'h00, 32'h1234_5678, 4'b0001, 2'b00};
    tbl[1]  = '{1'b0, 32'h00, 32'h0000_0078, 4'b0000, 2'b00};
    tbl[2]  = '{1'b1, 32'h0C, 32'hCAFE_F00D, 4'b1010, 2'b00};
    tbl[3]  = '{1'b0, 32'h0C, 32'hCA00_F000, 4'b0000, 2'b00};
    tbl[4]  = '{1'b1, 32'h40, 32'hDEAD_BEEF, 4'b1111, 2'b10};
    tbl[5]  = '{1'b0, 32'h40, 32'h0000_0000, 4'b0000, 2'b10};
    tbl[6]  = '{1'b0, 32'h00, 32'h0000_0078, 4'b0000, 2'b00};
    tbl[7]  = '{1'b1, 32'h3C, 32'h5A5A_5A5A, 4'b1111, 2'b00};
    tbl[8]  = '{1'b0, 32'h3C, 32'h5A5A_5A5A, 4'b0000, 2'b00};
    tbl[9]  = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'b0000, 2'b00};
    tbl[10] = '{1'b0, 32'h00, 32'h0000_0078, 4'b0000, 2'b00};
    tbl[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 2'b10};
    tbl[12] = '{1'b1, 32'h02, 32'hFFFF_FFFF, 4'b1111, UA_BRESP};
    tbl[13] = '{1'b0, 32'h00, UA_WORD0, 4'b0000, 2'b00};
    tbl[14] = '{1'b0, 32'h01, UA_RDATA, 4'b0000, UA_RRESP};

    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_ready", 32'({AWREADY, WREADY, ARREADY}), 32'b111);
    chk("rst_valid", 32'({BVALID, RVALID}), 32'b00);
    chk("rst_resp", 32'({BRESP, RRESP}), 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    ARESET = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr)
        do_write($sformatf("v%0d", i), tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp);
      else
        do_read($sformatf("v%0d", i), tbl[i].addr, tbl[i].data, tbl[i].resp);
    end

    // W three cycles ahead of AW.
    @(negedge ACLK);
    WDATA = 32'hAABB_CCDD; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("wfirst_rdy", 32'({AWREADY, WREADY, BVALID}), 32'b100);
    repeat (2) @(negedge ACLK);
    chk("wfirst_wait", 32'({AWREADY, WREADY, BVALID}), 32'b100);
    AWADDR = 32'h4; AWVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("wfirst_b", 32'({BVALID, BRESP}), 32'b100);
    @(negedge ACLK);
    do_read("wfirst_rd", 32'h4, 32'hAABB_CCDD, 2'b00);

    // B backpressure for 5 cycles with a new AW waiting.
    @(negedge ACLK);
    AWADDR = 32'h10; AWVALID = 1'b1; WDATA = 32'h0102_0304; WSTRB = 4'hF; WVALID = 1'b1;
    BREADY = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    WVALID = 1'b0; AWADDR = 32'h14;
    for (int c = 0; c < 5; c++) begin
      @(posedge ACLK);
      @(negedge ACLK);
      chk($sformatf("bhold%0d", c), 32'({BVALID, BRESP, AWREADY, WREADY}), 32'b10000);
    end
    BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("bhold_rel", 32'({BVALID, AWREADY, WREADY}), 32'b011);
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("bhold_aw", 32'({BVALID, AWREADY, WREADY}), 32'b001);
    WDATA = 32'h0BAD_CAFE; WVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("bhold_b2", 32'({BVALID, BRESP}), 32'b100);
    do_read("bhold_rd14", 32'h14, 32'h0BAD_CAFE, 2'b00);
    do_read("bhold_rd10", 32'h10, 32'h0102_0304, 2'b00);

    // Write commit and AR on the same edge to the same word.
    do_write("coll_pre", 32'h8, 32'h1111_1111, 4'hF, 2'b00);
    @(negedge ACLK);
    AWADDR = 32'h8; AWVALID = 1'b1; WDATA = 32'h2222_2222; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h8; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("coll_valid", 32'({BVALID, RVALID}), 32'b11);
    chk("coll_old", RDATA, 32'h1111_1111);
    @(negedge ACLK);
    do_read("coll_new", 32'h8, 32'h2222_2222, 2'b00);

    // Reset with only AW captured: the capture must not survive.
    @(negedge ACLK);
    AWADDR = 32'h4; AWVALID = 1'b1; BREADY = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("mrst_awheld", 32'({AWREADY, WREADY}), 32'b01);
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    chk("mrst_out", 32'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 32'b11100);
    WDATA = 32'h0000_0077; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    WVALID = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("mrst_noaw", 32'({BVALID, AWREADY, WREADY}), 32'b010);
    AWADDR = 32'h4; AWVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("mrst_b", 32'({BVALID, BRESP}), 32'b100);
    BREADY = 1'b1;
    @(negedge ACLK);
    do_read("mrst_rd4", 32'h4, 32'h0000_0077, 2'b00);
    do_read("mrst_clr", 32'h8, 32'h0000_0000, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
